// File: rtl/str_pack_pkg.sv
// -----------------------------------------------------------------------------
// str_pack_pkg
//   Shared types and constants for the serial-to-packed string assembler.
//
//   char_t            one character of the input stream
//   NUL               the character value that is dropped on input
//   str_pack_state_e  assembler state (COLLECT gathers characters, EMIT
//                     presents the packed word until the consumer takes it)
//
//   Helper functions keep the packing rules in one place so the top module
//   stays a plain FSM plus datapath.
// -----------------------------------------------------------------------------
package str_pack_pkg;

  typedef logic [7:0] char_t;

  localparam char_t NUL = 8'h00;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } str_pack_state_e;

  // True when the character carries content and must be packed.
  function automatic logic is_printable(input char_t c);
    return (c != NUL);
  endfunction

endpackage : str_pack_pkg

// File: rtl/str_pack_if.sv
// -----------------------------------------------------------------------------
// str_pack_if
//   Bundles the character input stream and the packed-word output stream of
//   str_pack.
//
//   Parameter
//     WIDTH_BYTES  output capacity in characters (>= 2)
//
//   Input stream (producer -> str_pack)
//     in_valid   a character is present
//     in_data    the character (8'h00 is NUL and is dropped)
//     in_last    the character ends the string
//     in_ready   str_pack can take a character
//
//   Output stream (str_pack -> consumer)
//     out_valid  a packed string is available
//     out_data   right-justified, NUL-left-padded packed string
//     out_len    number of non-NUL characters held in out_data
//     out_ovf    more characters arrived than out_data can hold
//     out_ready  the consumer takes the packed string
//
//   Handshake rule for both streams: a transfer happens on a rising clock
//   edge where valid and ready are both 1. The payload must be stable while
//   valid is 1 and ready is 0; payload is ignored whenever valid is 0.
//
//   Modports
//     slave   the str_pack side
//     master  the producer/consumer side (test environment or upstream logic)
// -----------------------------------------------------------------------------
interface str_pack_if
  import str_pack_pkg::*;
#(
  parameter int WIDTH_BYTES = 4
);

  localparam int DATA_W = 8 * WIDTH_BYTES;
  localparam int LEN_W  = $clog2(WIDTH_BYTES + 1);

  logic              in_valid;
  char_t             in_data;
  logic              in_last;
  logic              in_ready;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [LEN_W-1:0]  out_len;
  logic              out_ovf;
  logic              out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready,
    output out_valid,
    output out_data,
    output out_len,
    output out_ovf,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_len,
    input  out_ovf,
    output out_ready
  );

endinterface : str_pack_if

// File: rtl/str_pack.sv
// -----------------------------------------------------------------------------
// str_pack
//   Serial-to-packed string assembler. Takes one character per cycle from a
//   valid/ready stream, drops NUL characters, and packs the string into a
//   right-justified vector whose unfilled upper bytes are 8'h00 (the same
//   layout as assigning a string to a packed vector). The last character
//   received lands in out_data[7:0]. When more characters arrive than the
//   vector holds, the oldest ones fall off the top, keeping the last
//   WIDTH_BYTES characters.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-high; discards any partial or pending
//                string
//     bus        str_pack_if.slave (character input and packed output streams)
//     dbg_state  current FSM state, for observation only
//
//   Optional feature
//     STR_PACK_OVERFLOW_EN  when defined, out_ovf reports that characters
//                           were discarded; when undefined, out_ovf is 0.
//                           Truncation is the same either way.
//
//   Timing
//     The in_last handshake at edge N gives out_valid in cycle N+1. The
//     output handshake at edge M gives in_ready in cycle M+1. All outputs
//     come from registers or decode the state register alone.
// -----------------------------------------------------------------------------
module str_pack
  import str_pack_pkg::*;
#(
  parameter int WIDTH_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  str_pack_if.slave       bus,
  output str_pack_state_e dbg_state
);

  localparam int DATA_W = 8 * WIDTH_BYTES;
  localparam int LEN_W  = $clog2(WIDTH_BYTES + 1);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH_BYTES);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  str_pack_state_e   state;
  logic [DATA_W-1:0] data;
  logic [LEN_W-1:0]  len;

  logic              accept;  // input handshake this cycle
  logic              keep;    // accepted character that gets packed
  logic              release_out; // output handshake this cycle
  logic              full;

  // in_ready is the COLLECT decode, so the handshake only needs in_valid.
  assign accept      = bus.in_valid && (state == COLLECT);
  assign keep        = accept && is_printable(bus.in_data);
  assign release_out = bus.out_ready && (state == EMIT);
  assign full        = (len == LEN_MAX);

  // ---------------------------------------------------------------------------
  // FSM with shift register and character counter.
  // In COLLECT a kept character always shifts in; once the counter is full the
  // shift alone performs the truncation, so the counter simply saturates.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      data  <= '0;
      len   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (keep) begin
            data <= {data[DATA_W-9:0], bus.in_data};
            if (!full) begin
              len <= len + LEN_ONE;
            end
          end
          // A NUL carrying in_last still terminates the string.
          if (accept && bus.in_last) begin
            state <= EMIT;
          end
        end

        EMIT: begin
          if (release_out) begin
            state <= COLLECT;
            data  <= '0;
            len   <= '0;
          end
        end

        default: begin
          state <= COLLECT;
          data  <= '0;
          len   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef STR_PACK_OVERFLOW_EN
  logic ovf;

  // keep implies COLLECT and release_out implies EMIT, so the set and clear
  // conditions are mutually exclusive.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (release_out) begin
      ovf <= 1'b0;
    end else if (keep && full) begin
      ovf <= 1'b1;
    end
  end

  assign bus.out_ovf = ovf;
`else
  assign bus.out_ovf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_data  = data;
  assign bus.out_len   = len;
  assign dbg_state     = state;

endmodule : str_pack

// File: tb/tb_str_pack.sv
// -----------------------------------------------------------------------------
// tb_str_pack
//   Self-checking bench for str_pack (WIDTH_BYTES = 4). Directed scenarios
//   check fixed expected words; a randomized run compares against a reference
//   model that filters NULs from the whole string, keeps the last four
//   characters and builds the word by base-256 accumulation.
//   Honours STR_PACK_OVERFLOW_EN for the expected out_ovf value.
// -----------------------------------------------------------------------------
module tb_str_pack;
  import str_pack_pkg::*;

  localparam int WB = 4;
  localparam int W  = 8 * WB;
  localparam int LW = $clog2(WB + 1);
  localparam int TIMEOUT = 100;

`ifdef STR_PACK_OVERFLOW_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            reset;
  str_pack_state_e dbg_state;

  always #5 clk = ~clk;

  str_pack_if #(.WIDTH_BYTES(WB)) bus ();

  str_pack #(.WIDTH_BYTES(WB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  char_t           str_q[$];
  logic [W-1:0]    exp_q[$];
  logic [LW-1:0]   exp_len_q[$];
  logic            exp_ovf_q[$];

  // Reference model: whole-string view of str_q.
  task automatic model_push();
    char_t        nn[$];
    logic [W-1:0] word;
    int           first;
    word = '0;
    foreach (str_q[i]) if (str_q[i] != 8'h00) nn.push_back(str_q[i]);
    first = (nn.size() > WB) ? nn.size() - WB : 0;
    for (int i = first; i < nn.size(); i++) word = word * 256 + W'(nn[i]);
    exp_q.push_back(word);
    exp_len_q.push_back(LW'(nn.size() - first));
    exp_ovf_q.push_back(OVF_EN && (nn.size() > WB));
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send str_q; in_last on the final character only when with_last is set.
  task automatic send_str(input int max_gap, input bit with_last);
    for (int i = 0; i < str_q.size(); i++) begin
      int gap;
      int guard;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = char_t'($urandom);
        bus.in_last  = 1'($urandom_range(1, 0));
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = str_q[i];
      bus.in_last  = with_last && (i == str_q.size() - 1);
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < TIMEOUT) begin
        tick();
        guard++;
      end
      if (guard >= TIMEOUT) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=%b required 1 within %0d cycles", bus.in_ready, TIMEOUT);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  // Wait for out_valid, stall, then take the word.
  task automatic recv(input int stall, output logic [W-1:0] d,
                      output logic [LW-1:0] l, output logic o, output bit timed_out);
    int guard;
    guard = 0;
    timed_out = 1'b0;
    while (bus.out_valid !== 1'b1 && guard < TIMEOUT) begin
      tick();
      guard++;
    end
    if (guard >= TIMEOUT) timed_out = 1'b1;
    repeat (stall) tick();
    d = bus.out_data;
    l = bus.out_len;
    o = bus.out_ovf;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
    n_cmp++; if (bus.out_len !== '0) begin n_fail++; $display("FAIL reset_out_len: got %0d required 0", bus.out_len); end
    n_cmp++; if (bus.out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b required 0", bus.out_ovf); end
    n_cmp++; if (dbg_state !== COLLECT) begin n_fail++; $display("FAIL reset_state: got %0d required COLLECT", dbg_state); end
  endtask

  task automatic test_nul_drop();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    str_q = '{8'h00, 8'h41, 8'h00};
    send_str(0, 1'b1);
    recv(0, d, l, o, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL nul1_timeout: out_valid never rose"); end
    n_cmp++; if (d !== 32'h00000041) begin n_fail++; $display("FAIL nul1_data: got %h required 00000041", d); end
    n_cmp++; if (l !== 3'd1) begin n_fail++; $display("FAIL nul1_len: got %0d required 1", l); end
    n_cmp++; if (o !== 1'b0) begin n_fail++; $display("FAIL nul1_ovf: got %b required 0", o); end

    str_q = '{8'h42, 8'h00, 8'h41};
    send_str(0, 1'b1);
    recv(1, d, l, o, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL nul2_timeout: out_valid never rose"); end
    n_cmp++; if (d !== 32'h00004241) begin n_fail++; $display("FAIL nul2_data: got %h required 00004241", d); end
    n_cmp++; if (l !== 3'd2) begin n_fail++; $display("FAIL nul2_len: got %0d required 2", l); end
  endtask

  task automatic test_empty();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    str_q = '{8'h00};
    send_str(0, 1'b1);
    // One cycle after the in_last edge.
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL empty_latency: out_valid=%b required 1 at N+1", bus.out_valid); end
    n_cmp++; if (dbg_state !== EMIT) begin n_fail++; $display("FAIL empty_state: got %0d required EMIT", dbg_state); end
    recv(0, d, l, o, to);
    n_cmp++; if (d !== '0) begin n_fail++; $display("FAIL empty_data: got %h required 0", d); end
    n_cmp++; if (l !== '0) begin n_fail++; $display("FAIL empty_len: got %0d required 0", l); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    str_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    send_str(0, 1'b1);
    recv(0, d, l, o, to);
    n_cmp++; if (d !== 32'h43444546) begin n_fail++; $display("FAIL ovf_data: got %h required 43444546", d); end
    n_cmp++; if (l !== 3'd4) begin n_fail++; $display("FAIL ovf_len: got %0d required 4", l); end
    n_cmp++; if (o !== OVF_EN) begin n_fail++; $display("FAIL ovf_flag: got %b required %b", o, OVF_EN); end
    // Exactly full is not an overflow, and the flag must have been cleared.
    str_q = '{8'h57, 8'h58, 8'h59, 8'h5A};
    send_str(0, 1'b1);
    recv(0, d, l, o, to);
    n_cmp++; if (d !== 32'h5758595A) begin n_fail++; $display("FAIL full_data: got %h required 5758595a", d); end
    n_cmp++; if (l !== 3'd4) begin n_fail++; $display("FAIL full_len: got %0d required 4", l); end
    n_cmp++; if (o !== 1'b0) begin n_fail++; $display("FAIL full_ovf: got %b required 0", o); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    str_q = '{8'h48, 8'h49};
    send_str(0, 1'b1);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      // Offered characters during EMIT must be ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h51;
      bus.in_last  = 1'b1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b required 1", c, bus.out_valid); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", c, bus.in_ready); end
      n_cmp++; if (bus.out_data !== 32'h00004849) begin n_fail++; $display("FAIL bp_data[%0d]: got %h required 00004849", c, bus.out_data); end
      n_cmp++; if (bus.out_len !== 3'd2) begin n_fail++; $display("FAIL bp_len[%0d]: got %0d required 2", c, bus.out_len); end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_turnaround: in_ready=%b required 1 at M+1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: out_valid=%b required 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL bp_clear: out_data=%h required 0", bus.out_data); end
    // First byte of the next string offered at M+1.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h4A;
    bus.in_last  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_accept: out_valid=%b required 1", bus.out_valid); end
    recv(0, d, l, o, to);
    n_cmp++; if (d !== 32'h0000004A) begin n_fail++; $display("FAIL bp_next_data: got %h required 0000004a", d); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    str_q = '{8'h41, 8'h42};
    send_str(0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.out_len !== '0) begin n_fail++; $display("FAIL rmid_len_cleared: got %0d required 0", bus.out_len); end
    str_q = '{8'h43};
    send_str(0, 1'b1);
    recv(0, d, l, o, to);
    n_cmp++; if (d !== 32'h00000043) begin n_fail++; $display("FAIL rmid_data: got %h required 00000043", d); end
    n_cmp++; if (l !== 3'd1) begin n_fail++; $display("FAIL rmid_len: got %0d required 1", l); end
    // Reset while a word is pending drops it.
    str_q = '{8'h58, 8'h59};
    send_str(0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL remit_valid: got %b required 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL remit_in_ready: got %b required 1", bus.in_ready); end
    n_cmp++; if (bus.out_data !== '0) begin n_fail++; $display("FAIL remit_data: got %h required 0", bus.out_data); end
  endtask

  task automatic test_random();
    logic [W-1:0] d; logic [LW-1:0] l; logic o; bit to;
    logic [W-1:0] ed; logic [LW-1:0] el; logic eo;
    for (int s = 0; s < 30; s++) begin
      int n;
      n = int'($urandom_range(9, 1));
      str_q.delete();
      for (int k = 0; k < n; k++)
        str_q.push_back(($urandom_range(3, 0) == 0) ? 8'h00 : char_t'($urandom_range(255, 1)));
      model_push();
      send_str(int'($urandom_range(2, 0)), 1'b1);
      recv(int'($urandom_range(3, 0)), d, l, o, to);
      ed = exp_q.pop_front();
      el = exp_len_q.pop_front();
      eo = exp_ovf_q.pop_front();
      n_cmp++; if (to) begin n_fail++; $display("FAIL rnd_timeout[%0d]: out_valid never rose", s); end
      n_cmp++; if (d !== ed) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h required %h", s, d, ed); end
      n_cmp++; if (l !== el) begin n_fail++; $display("FAIL rnd_len[%0d]: got %0d required %0d", s, l, el); end
      n_cmp++; if (o !== eo) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b required %b", s, o, eo); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_turnaround[%0d]: in_ready=%b required 1", s, bus.in_ready); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_nul_drop();
    test_empty();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_str_pack

// File: doc/str_pack.md
# str_pack

Serial-to-packed string assembler: accepts one character per cycle on a valid/ready byte stream and packs a complete string into a right-justified, NUL-left-padded vector, matching SystemVerilog string-to-vector assignment semantics. It is the write side of our packed-vector/string conversion path. The read side unpacks a vector into a string and drops NUL bytes. This block performs the inverse: it drops NUL input bytes and emits the packed word plus its character count.

## Interface
- `WIDTH_BYTES`, default 4: output capacity in characters. Must be at least 2.
- `clk` input 1: the only clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: an input character is present.
- `in_data` input 8: the input character. `8'h00` is treated as NUL.
- `in_last` input 1: marks the final character of the string.
- `in_ready` output 1: the block can accept an input character.
- `out_valid` output 1: a packed string is available.
- `out_data` output 8*WIDTH_BYTES: the packed string. The last character received is in `[7:0]`.
- `out_len` output $clog2(WIDTH_BYTES+1): the number of non-NUL characters, from 0 to WIDTH_BYTES.
- `out_ready` input 1: the consumer accepts the packed string.
- `out_ovf` output 1: more than WIDTH_BYTES non-NUL characters were received. See Configuration.

## Operation
- There are two states, `COLLECT` and `EMIT`.
- **Reset:** the state is `COLLECT`. `in_ready`=1, `out_valid`=0, `out_data`=0, `out_len`=0, `out_ovf`=0.
- **COLLECT:**
  - `in_ready`=1. A character is accepted when `in_valid && in_ready`.
  - An accepted non-NUL character shifts in: `data <= {data[8*WIDTH_BYTES-9:0], in_data}`.
  - `len` increments and saturates at WIDTH_BYTES.
  - An accepted NUL character leaves `data` and `len` unchanged.
  - An accepted character with `in_last`=1 moves the state to `EMIT`. This applies whether the character is NUL or not.
- **EMIT:**
  - `in_ready`=0 and `out_valid`=1.
  - `out_data`, `out_len` and `out_ovf` are held stable until `out_valid && out_ready`.
  - On that handshake the block clears `data`, `len` and `ovf`, and returns to `COLLECT`.
- **Overflow:** a non-NUL character accepted while `len`==WIDTH_BYTES still shifts in, which discards the oldest character. The result keeps the last WIDTH_BYTES characters, which is the same truncation as string-to-vector assignment.
- **Padding:** unfilled upper bytes are always `8'h00`. An empty string produces `out_data`=0 and `out_len`=0.
- **Outside a handshake:** `in_data` and `in_last` are ignored when `in_valid`=0 or `in_ready`=0.
- **Reset mid-operation:** reset overrides everything in the same cycle. A partial string is discarded, and a pending `EMIT` is dropped without a handshake.

## Timing
- **Input rate:** one character per cycle in `COLLECT`.
- **Output latency:** the `in_last` handshake occurs at edge N. `out_valid`=1 from cycle N+1.
- **Turnaround:** the output handshake occurs at edge M. `in_ready`=1 in cycle M+1. Each string therefore costs at least one input bubble.
- **Simultaneous events:** `in_valid` is not accepted in `EMIT`, so input and output handshakes never coincide.
- **Registered outputs:** `out_data`, `out_len` and `out_ovf` come directly from registers, with no combinational path from `in_*`. `in_ready` and `out_valid` decode the state register only. There is no combinational path from `out_ready` to any output.

## Configuration
- **Macro:** `STR_PACK_OVERFLOW_EN`.
- **Defined:**
  - An `ovf` register is set by any non-NUL character accepted while `len`==WIDTH_BYTES.
  - It is presented on `out_ovf` during `EMIT` and cleared on the output handshake or on reset.
- **Undefined:**
  - No `ovf` register is built and `out_ovf` is tied to 0.
  - Truncation behaviour is identical to the defined case.

## Structure
- **Shared package `str_pack_pkg`:**
  - Typedef `char_t` (`logic [7:0]`).
  - Constant `NUL` = `8'h00`.
  - Enum `str_pack_state_e` {`COLLECT`, `EMIT`}.
- **Sub-modules:** none. The shift register, counter and FSM are small, and the design is a single module.

## Test plan
- **NUL dropping, one character:** send 00, 41, 00(last) → `out_data`=32'h00000041, `out_len`=1, `out_ovf`=0.
- **NUL dropping, two characters:** send 42, 00, 41(last) → `out_data`=32'h00004241 ("BA"), `out_len`=2.
- **Empty string:** send a single 00(last) → `out_valid` at N+1, `out_data`=0, `out_len`=0.
- **Overflow:** send "ABCDEF" with last on 'F' → `out_data`=32'h43444546, `out_len`=4. `out_ovf`=1 with `STR_PACK_OVERFLOW_EN` and 0 without it.
- **Backpressure:** hold `out_ready`=0 for 3 cycles in `EMIT` → `out_valid` stays 1, outputs are stable, `in_ready`=0. After the handshake, the next string's first byte is accepted at M+1.
- **Reset mid-string:** send "AB" (no last), then pulse `reset`, then send 43(last) → `out_data`=32'h00000043, `out_len`=1.
